// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder cell is time-shared across all
// bit positions, adding two WIDTH-bit operands LSB first at one bit per clock.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovfl,
    output logic [1:0]       dbg_state
);
    // Handshake: start is a level request sampled only in IDLE or DONE. While
    // busy is high, start and the operand inputs are ignored. done is a one-cycle
    // pulse, and Sum/Cout/Ovfl are valid from that cycle until the next done.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = start && (state == IDLE || state == DONE);
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
            Ovfl   <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            sum_sh <= '0;
            carry  <= Cin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + 1'b1;
            // On the MSB, carry holds the carry into the MSB and fa_co the carry out.
            if (last_bit) begin
                Sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                Cout <= fa_co;
                Ovfl <= carry ^ fa_co;
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: directed scenarios and random operations on an
// 8-bit instance, plus an exhaustive sweep of a 2-bit instance.

module tb_serial_add_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovfl8;
    logic [7:0] sum8;
    logic [1:0] dbg8;

    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2, ovfl2;
    logic [1:0] sum2;
    logic [1:0] dbg2;

    int checks = 0;
    int passes = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovfl(ovfl8),
        .dbg_state(dbg8)
    );

    serial_add_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
        .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2), .Ovfl(ovfl2),
        .dbg_state(dbg2)
    );

    // Reference: plain arithmetic sum, signed overflow from operand/result signs.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci);
        logic [8:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        ov = (a[7] == b[7]) && (t[7] != a[7]);
        return {ov, t[8], t[7:0]};
    endfunction

    function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b,
                                          input logic ci);
        logic [2:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + {2'd0, ci};
        ov = (a[1] == b[1]) && (t[1] != a[1]);
        return {ov, t[2], t[1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to done, scrambling the operand inputs
    // while it runs. done_at counts edges after the accepting edge (-1 = timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int busy_n, output int done_at, output logic [9:0] res);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        tick();
        start8  = 1'b0;
        busy_n  = 0;
        done_at = -1;
        res     = '0;
        for (int e = 0; e < 40; e++) begin
            if (done8) begin
                done_at = e;
                res     = {ovfl8, cout8, sum8};
                break;
            end
            if (busy8) busy_n++;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy8, done8, ovfl8, cout8, sum8} !== 12'd0) begin
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovfl=%b, want all 0",
                     busy8, done8, sum8, cout8, ovfl8);
        end else passes++;
        checks++;
        if ({busy2, done2, ovfl2, cout2, sum2} !== 6'd0) begin
            $display("FAIL reset2: got busy=%b done=%b sum=%h cout=%b ovfl=%b, want all 0",
                     busy2, done2, sum2, cout2, ovfl2);
        end else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'h00};
        logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'h00};
        logic       tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] want[3] = '{{1'b1, 1'b0, 8'h96}, {1'b0, 1'b1, 8'h00}, {1'b0, 1'b0, 8'h01}};
        int busy_n, done_at;
        logic [9:0] res;
        for (int i = 0; i < 3; i++) begin
            run8(ta[i], tb[i], tc[i], busy_n, done_at, res);
            checks++;
            if (done_at !== 8 || busy_n !== 8) begin
                $display("FAIL directed_latency[%0d]: done after %0d edges busy %0d cycles, want 8/8",
                         i, done_at, busy_n);
            end else passes++;
            checks++;
            if (res !== want[i]) begin
                $display("FAIL directed_result[%0d]: {ovfl,cout,sum}=%h, want %h", i, res, want[i]);
            end else passes++;
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        logic [7:0] first_sum = '0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (done8) begin
                if (n_done == 0) first_sum = sum8;
                n_done++;
            end
            tick();
        end
        checks++;
        if (n_done !== 1) $display("FAIL ignore_start_count: %0d done pulses, want 1", n_done);
        else passes++;
        checks++;
        if (first_sum !== 8'h46) $display("FAIL ignore_start_sum: sum=%h, want 46", first_sum);
        else passes++;
        checks++;
        if (busy8 !== 1'b0) $display("FAIL ignore_start_idle: busy=%b, want 0", busy8);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int done_at = -1;
        bit seen = 0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int e = 0; e < 40 && !seen; e++) begin
            if (done8) seen = 1;
            else tick();
        end
        checks++;
        if (!seen || sum8 !== 8'h46) $display("FAIL b2b_first: seen=%0d sum=%h, want 1/46", seen, sum8);
        else passes++;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) $display("FAIL b2b_no_bubble: busy=%b after DONE, want 1", busy8);
        else passes++;
        tick(); tick();
        checks++;
        if (sum8 !== 8'h46) $display("FAIL b2b_hold: sum=%h mid-operation, want 46", sum8);
        else passes++;
        for (int e = 2; e < 40; e++) begin
            if (done8) begin
                done_at = e;
                break;
            end
            tick();
        end
        checks++;
        if (done_at !== 8) $display("FAIL b2b_latency: done after %0d edges, want 8", done_at);
        else passes++;
        checks++;
        if ({ovfl8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            $display("FAIL b2b_second: {ovfl,cout,sum}=%h, want 300", {ovfl8, cout8, sum8});
        end else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        int busy_n, done_at, n_done = 0;
        logic [9:0] res;
        run8(8'h12, 8'h34, 1'b0, busy_n, done_at, res);
        tick();
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy8, done8, ovfl8, cout8, sum8} !== 12'd0) begin
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovfl=%b, want all 0",
                     busy8, done8, sum8, cout8, ovfl8);
        end else passes++;
        for (int e = 0; e < 20; e++) begin
            if (done8) n_done++;
            tick();
        end
        checks++;
        if (n_done !== 0) $display("FAIL reset_mid_no_done: %0d done pulses, want 0", n_done);
        else passes++;
        run8(8'h77, 8'h11, 1'b1, busy_n, done_at, res);
        checks++;
        if (done_at !== 8 || res !== model8(8'h77, 8'h11, 1'b1)) begin
            $display("FAIL reset_mid_fresh: done_at=%0d res=%h, want 8/%h",
                     done_at, res, model8(8'h77, 8'h11, 1'b1));
        end else passes++;
        tick();
    endtask

    task automatic test_random();
        int busy_n, done_at;
        logic [9:0] res, want;
        logic [7:0] a, b;
        logic       ci;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp_q.push_back(model8(a, b, ci));
            run8(a, b, ci, busy_n, done_at, res);
            want = exp_q.pop_front();
            checks++;
            if (done_at !== 8 || res !== want) begin
                $display("FAIL random[%0d]: %h+%h+%b done_at=%0d res=%h, want 8/%h",
                         i, a, b, ci, done_at, res, want);
            end else passes++;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    task automatic test_w2_sweep();
        int errors = 0;
        int done_at;
        logic [3:0] got, want;
        for (int v = 0; v < 32; v++) begin
            a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
            tick();
            start2  = 1'b0;
            done_at = -1;
            got     = '0;
            for (int e = 0; e < 10; e++) begin
                if (done2) begin
                    done_at = e;
                    got     = {ovfl2, cout2, sum2};
                    break;
                end
                tick();
            end
            want = model2(v[4:3], v[2:1], v[0]);
            checks++;
            if (done_at !== 2 || got !== want) begin
                $display("FAIL w2_sweep: a=%0d b=%0d cin=%0d done_at=%0d res=%h, want 2/%h",
                         v[4:3], v[2:1], v[0], done_at, got, want);
                errors++;
            end else passes++;
            tick();
        end
        if (errors == 0) $display("w2 sweep: all 32 cases match");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_w2_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
